// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order reorder buffer that sits after the mapper.
//   Allocates one uop per cycle at the tail, accepts one out-of-order completion per
//   cycle by tag, and retires the oldest completed uop in program order. A retiring
//   exception flushes the whole buffer. Two combinational operand lookups by tag let
//   the mapper resolve source readiness, with bypass from the same-cycle completion.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_alloc_*                       allocation request and payload from the mapper
//   o_rob_write_ptr, o_rob_full     tag of the next allocation, buffer full
//   i_cmpl_*                        functional-unit completion (tag, result, exception)
//   i_rd{1,2}_tag, o_rd{1,2}_*      operand lookups (ready flag and result)
//   o_retire_*                      head uop retiring this cycle and its payload
//   o_flush                         pipeline flush, raised with an exception retire
module reorder_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PTR_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alloc_valid,
    input  logic [4:0]       i_alloc_dr,
    input  logic [31:0]      i_alloc_pc,
    input  logic             i_alloc_eoi,
    input  logic             i_alloc_exception,
    output logic [31:0]      o_rob_write_ptr,
    output logic             o_rob_full,
    input  logic             i_cmpl_valid,
    input  logic [PTR_W-1:0] i_cmpl_tag,
    input  logic [31:0]      i_cmpl_result,
    input  logic             i_cmpl_exception,
    input  logic [PTR_W-1:0] i_rd1_tag,
    output logic             o_rd1_ready,
    output logic [31:0]      o_rd1_data,
    input  logic [PTR_W-1:0] i_rd2_tag,
    output logic             o_rd2_ready,
    output logic [31:0]      o_rd2_data,
    output logic             o_retire_valid,
    output logic [4:0]       o_retire_dr,
    output logic [31:0]      o_retire_data,
    output logic [31:0]      o_retire_pc,
    output logic             o_retire_eoi,
    output logic             o_retire_exception,
    output logic             o_flush
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_exc;
    logic [DEPTH-1:0] r_eoi;
    logic [4:0]       r_dr   [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_data [DEPTH];

    logic w_full;
    logic w_retire;
    logic w_flush;
    logic w_alloc;
    logic w_cmpl;
    logic w_byp1;
    logic w_byp2;

    assign w_full   = (r_count == FullCount);
    assign w_retire = r_valid[r_head] & r_done[r_head];
    assign w_flush  = w_retire & r_exc[r_head];
    // Full is judged on the registered count, so a same-cycle retire never frees a slot.
    assign w_alloc  = i_alloc_valid & ~w_full & ~w_flush;
    assign w_cmpl   = i_cmpl_valid & r_valid[i_cmpl_tag];

    always_ff @(posedge i_clk) begin
        if (i_rst || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            // A completion never targets the tail slot being allocated: that slot is
            // invalid whenever an allocation is possible.
            if (w_cmpl) begin
                r_done[i_cmpl_tag] <= 1'b1;
                r_data[i_cmpl_tag] <= i_cmpl_result;
                r_exc[i_cmpl_tag]  <= r_exc[i_cmpl_tag] | i_cmpl_exception;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                // Decode exceptions need no FU completion to retire.
                r_done[r_tail]  <= i_alloc_exception;
                r_exc[r_tail]   <= i_alloc_exception;
                r_eoi[r_tail]   <= i_alloc_eoi;
                r_dr[r_tail]    <= i_alloc_dr;
                r_pc[r_tail]    <= i_alloc_pc;
                r_data[r_tail]  <= '0;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rob_write_ptr = {{(32 - PTR_W){1'b0}}, r_tail};
    assign o_rob_full      = w_full;
    assign o_flush         = w_flush;

    always_comb begin
        o_retire_valid     = w_retire;
        o_retire_dr        = '0;
        o_retire_data      = '0;
        o_retire_pc        = '0;
        o_retire_eoi       = 1'b0;
        o_retire_exception = 1'b0;
        if (w_retire) begin
            o_retire_dr        = r_dr[r_head];
            o_retire_data      = r_data[r_head];
            o_retire_pc        = r_pc[r_head];
            o_retire_eoi       = r_eoi[r_head];
            o_retire_exception = r_exc[r_head];
        end
    end

    // Operand lookups: the same-cycle completion bypasses storage.
    assign w_byp1 = i_cmpl_valid & (i_cmpl_tag == i_rd1_tag) & r_valid[i_rd1_tag];
    assign w_byp2 = i_cmpl_valid & (i_cmpl_tag == i_rd2_tag) & r_valid[i_rd2_tag];

    always_comb begin
        o_rd1_ready = 1'b0;
        o_rd1_data  = '0;
        if (w_byp1) begin
            o_rd1_ready = 1'b1;
            o_rd1_data  = i_cmpl_result;
        end else if (r_valid[i_rd1_tag] && r_done[i_rd1_tag]) begin
            o_rd1_ready = 1'b1;
            o_rd1_data  = r_data[i_rd1_tag];
        end
    end

    always_comb begin
        o_rd2_ready = 1'b0;
        o_rd2_data  = '0;
        if (w_byp2) begin
            o_rd2_ready = 1'b1;
            o_rd2_data  = i_cmpl_result;
        end else if (r_valid[i_rd2_tag] && r_done[i_rd2_tag]) begin
            o_rd2_ready = 1'b1;
            o_rd2_data  = r_data[i_rd2_tag];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic for reorder_buffer,
// checked every cycle against a program-order queue model of the buffer.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_dr;
    logic [31:0] alloc_pc;
    logic        alloc_eoi;
    logic        alloc_exception;
    logic [31:0] rob_write_ptr;
    logic        rob_full;
    logic        cmpl_valid;
    logic [4:0]  cmpl_tag;
    logic [31:0] cmpl_result;
    logic        cmpl_exception;
    logic [4:0]  rd1_tag;
    logic        rd1_ready;
    logic [31:0] rd1_data;
    logic [4:0]  rd2_tag;
    logic        rd2_ready;
    logic [31:0] rd2_data;
    logic        retire_valid;
    logic [4:0]  retire_dr;
    logic [31:0] retire_data;
    logic [31:0] retire_pc;
    logic        retire_eoi;
    logic        retire_exception;
    logic        flush;

    reorder_buffer #(.DEPTH(32), .PTR_W(5)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_alloc_valid      (alloc_valid),
        .i_alloc_dr         (alloc_dr),
        .i_alloc_pc         (alloc_pc),
        .i_alloc_eoi        (alloc_eoi),
        .i_alloc_exception  (alloc_exception),
        .o_rob_write_ptr    (rob_write_ptr),
        .o_rob_full         (rob_full),
        .i_cmpl_valid       (cmpl_valid),
        .i_cmpl_tag         (cmpl_tag),
        .i_cmpl_result      (cmpl_result),
        .i_cmpl_exception   (cmpl_exception),
        .i_rd1_tag          (rd1_tag),
        .o_rd1_ready        (rd1_ready),
        .o_rd1_data         (rd1_data),
        .i_rd2_tag          (rd2_tag),
        .o_rd2_ready        (rd2_ready),
        .o_rd2_data         (rd2_data),
        .o_retire_valid     (retire_valid),
        .o_retire_dr        (retire_dr),
        .o_retire_data      (retire_data),
        .o_retire_pc        (retire_pc),
        .o_retire_eoi       (retire_eoi),
        .o_retire_exception (retire_exception),
        .o_flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: uops in program order, oldest first.
    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  dr;
        logic [31:0] pc;
        logic        eoi;
        logic        done;
        logic        exc;
        logic [31:0] data;
    } ent_t;

    ent_t       m_q[$];
    logic [4:0] m_tail  = '0;
    bit         m_known = 1'b0;

    function automatic int find(input logic [4:0] t);
        for (int i = 0; i < m_q.size(); i++) if (m_q[i].tag == t) return i;
        return -1;
    endfunction

    task automatic lookup(input logic [4:0] t, output logic r, output logic [31:0] d);
        int k;
        k = find(t);
        r = 1'b0;
        d = '0;
        if (k >= 0) begin
            if (cmpl_valid && cmpl_tag == t) begin
                r = 1'b1;
                d = cmpl_result;
            end else if (m_q[k].done) begin
                r = 1'b1;
                d = m_q[k].data;
            end
        end
    endtask

    // Compare and advance the model once per cycle, while inputs are stable.
    always @(negedge clk) begin
        logic        e_ret;
        logic        e_flush;
        logic        e_full;
        logic        r1;
        logic        r2;
        logic [31:0] d1;
        logic [31:0] d2;
        int          k;
        e_full  = (m_q.size() == 32);
        e_ret   = (m_q.size() > 0) && m_q[0].done;
        e_flush = e_ret && m_q[0].exc;
        if (m_known) begin
            lookup(rd1_tag, r1, d1);
            lookup(rd2_tag, r2, d2);
            chk("write_ptr", rob_write_ptr, {27'd0, m_tail});
            chk("full", {31'd0, rob_full}, {31'd0, e_full});
            chk("retire_valid", {31'd0, retire_valid}, {31'd0, e_ret});
            chk("flush", {31'd0, flush}, {31'd0, e_flush});
            chk("retire_dr", {27'd0, retire_dr}, e_ret ? {27'd0, m_q[0].dr} : 32'd0);
            chk("retire_pc", retire_pc, e_ret ? m_q[0].pc : 32'd0);
            chk("retire_data", retire_data, e_ret ? m_q[0].data : 32'd0);
            chk("retire_eoi", {31'd0, retire_eoi}, e_ret ? {31'd0, m_q[0].eoi} : 32'd0);
            chk("retire_exc", {31'd0, retire_exception}, e_ret ? {31'd0, m_q[0].exc} : 32'd0);
            chk("rd1_ready", {31'd0, rd1_ready}, {31'd0, r1});
            chk("rd1_data", rd1_data, d1);
            chk("rd2_ready", {31'd0, rd2_ready}, {31'd0, r2});
            chk("rd2_data", rd2_data, d2);
        end
        if (rst) begin
            m_q.delete();
            m_tail  = '0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (e_flush) begin
                m_q.delete();
                m_tail = '0;
            end else begin
                if (cmpl_valid) begin
                    k = find(cmpl_tag);
                    if (k >= 0) begin
                        m_q[k].done = 1'b1;
                        m_q[k].data = cmpl_result;
                        m_q[k].exc  = m_q[k].exc | cmpl_exception;
                    end
                end
                if (e_ret) void'(m_q.pop_front());
                if (alloc_valid && !e_full) begin
                    m_q.push_back('{tag: m_tail, dr: alloc_dr, pc: alloc_pc, eoi: alloc_eoi,
                                    done: alloc_exception, exc: alloc_exception, data: 32'd0});
                    m_tail = m_tail + 5'd1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid     = 1'b0;
        alloc_dr        = '0;
        alloc_pc        = '0;
        alloc_eoi       = 1'b0;
        alloc_exception = 1'b0;
        cmpl_valid      = 1'b0;
        cmpl_tag        = '0;
        cmpl_result     = '0;
        cmpl_exception  = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [4:0] dr, input logic exc);
        alloc_valid     = 1'b1;
        alloc_pc        = pc;
        alloc_dr        = dr;
        alloc_eoi       = pc[2];
        alloc_exception = exc;
    endtask

    task automatic set_cmpl(input logic [4:0] t, input logic [31:0] res, input logic exc);
        cmpl_valid     = 1'b1;
        cmpl_tag       = t;
        cmpl_result    = res;
        cmpl_exception = exc;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rd1_tag = '0;
        rd2_tag = 5'd1;
        idle();
        step();
        do_reset();
        #1;
        chk("lit_reset_wptr", rob_write_ptr, 32'd0);
        chk("lit_reset_full", {31'd0, rob_full}, 32'd0);
        chk("lit_reset_retire", {31'd0, retire_valid}, 32'd0);
        chk("lit_reset_flush", {31'd0, flush}, 32'd0);
        step();

        // Fill all 32 entries, then try a 33rd allocation.
        for (int i = 0; i < 32; i++) begin
            set_alloc(32'h100 + 32'(4 * i), 5'(i + 1), 1'b0);
            #1;
            chk("lit_fill_wptr", rob_write_ptr, 32'(i));
            step();
        end
        idle();
        #1;
        chk("lit_fill_wrap", rob_write_ptr, 32'd0);
        chk("lit_fill_full", {31'd0, rob_full}, 32'd1);
        set_alloc(32'h900, 5'd9, 1'b0);
        step();
        idle();
        #1;
        chk("lit_drop_full", {31'd0, rob_full}, 32'd1);
        chk("lit_drop_wptr", rob_write_ptr, 32'd0);
        // Head done while full: retire and blocked allocation in the same cycle.
        set_cmpl(5'd0, 32'h77, 1'b0);
        step();
        idle();
        set_alloc(32'h904, 5'd9, 1'b0);
        #1;
        chk("lit_fullret_valid", {31'd0, retire_valid}, 32'd1);
        chk("lit_fullret_full", {31'd0, rob_full}, 32'd1);
        step();
        idle();
        #1;
        chk("lit_fullret_after", {31'd0, rob_full}, 32'd0);
        chk("lit_fullret_wptr", rob_write_ptr, 32'd0);
        set_alloc(32'h908, 5'd9, 1'b0);
        step();
        idle();
        #1;
        chk("lit_refill_wptr", rob_write_ptr, 32'd1);
        chk("lit_refill_full", {31'd0, rob_full}, 32'd1);

        // Out-of-order completion, in-order retire.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(32'h100 + 32'(4 * i), 5'(i + 3), 1'b0);
            step();
        end
        idle();
        set_cmpl(5'd2, 32'h22, 1'b0);
        step();
        set_cmpl(5'd0, 32'hAA, 1'b0);
        #1;
        chk("lit_no_fwd", {31'd0, retire_valid}, 32'd0);
        step();
        idle();
        #1;
        chk("lit_ret0_valid", {31'd0, retire_valid}, 32'd1);
        chk("lit_ret0_data", retire_data, 32'hAA);
        chk("lit_ret0_pc", retire_pc, 32'h100);
        step();
        #1;
        chk("lit_blocked", {31'd0, retire_valid}, 32'd0);
        set_cmpl(5'd1, 32'h11, 1'b0);
        step();
        idle();
        #1;
        chk("lit_ret1_data", retire_data, 32'h11);
        step();
        #1;
        chk("lit_ret2_data", retire_data, 32'h22);
        chk("lit_ret2_valid", {31'd0, retire_valid}, 32'd1);
        step();

        // Bypass lookup, then storage lookup.
        set_alloc(32'h10C, 5'd6, 1'b0);
        step();
        idle();
        rd1_tag = 5'd3;
        set_cmpl(5'd3, 32'h55, 1'b0);
        #1;
        chk("lit_byp_ready", {31'd0, rd1_ready}, 32'd1);
        chk("lit_byp_data", rd1_data, 32'h55);
        step();
        idle();
        #1;
        chk("lit_store_ready", {31'd0, rd1_ready}, 32'd1);
        chk("lit_store_data", rd1_data, 32'h55);
        step();

        // Retiring exception at entry 5 with tail at 9 flushes everything.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_alloc(32'h200 + 32'(4 * i), 5'(i + 1), 1'b0);
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            set_cmpl(5'(i), 32'h300 + 32'(i), 1'b0);
            step();
        end
        idle();
        step();
        set_cmpl(5'd5, 32'h305, 1'b1);
        step();
        idle();
        set_alloc(32'h400, 5'd7, 1'b0);
        #1;
        chk("lit_flush", {31'd0, flush}, 32'd1);
        chk("lit_flush_exc", {31'd0, retire_exception}, 32'd1);
        chk("lit_flush_pc", retire_pc, 32'h214);
        step();
        idle();
        #1;
        chk("lit_postflush_wptr", rob_write_ptr, 32'd0);
        chk("lit_postflush_ret", {31'd0, retire_valid}, 32'd0);
        chk("lit_postflush_flush", {31'd0, flush}, 32'd0);
        step();

        // Reset mid-stream with 10 live entries; a stale completion is ignored.
        for (int i = 0; i < 10; i++) begin
            set_alloc(32'h500 + 32'(4 * i), 5'(i + 1), 1'b0);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd1_tag = 5'd4;
        set_cmpl(5'd4, 32'h99, 1'b0);
        #1;
        chk("lit_midrst_wptr", rob_write_ptr, 32'd0);
        chk("lit_midrst_rd1", {31'd0, rd1_ready}, 32'd0);
        chk("lit_midrst_ret", {31'd0, retire_valid}, 32'd0);
        step();
        idle();
        #1;
        chk("lit_stale_ret", {31'd0, retire_valid}, 32'd0);
        chk("lit_stale_rd1", {31'd0, rd1_ready}, 32'd0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 3) != 0)
                set_alloc($urandom & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * 4),
                          5'($urandom), ($urandom_range(0, 79) == 0));
            if ($urandom_range(0, 2) != 0) begin
                if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                    set_cmpl(m_q[$urandom_range(0, m_q.size() - 1)].tag, $urandom,
                             ($urandom_range(0, 79) == 0));
                else
                    set_cmpl(5'($urandom), $urandom, ($urandom_range(0, 79) == 0));
            end
            if (m_q.size() > 0 && $urandom_range(0, 1) == 0)
                rd1_tag = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                rd1_tag = 5'($urandom);
            rd2_tag = (cmpl_valid && $urandom_range(0, 2) == 0) ? cmpl_tag : 5'($urandom);
            step();
        end
        idle();
        rst = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order reorder buffer that sits after the mapper.
- Returns `rob_write_ptr` and `rob_full` to the mapper, and accepts one uop allocation per cycle.
- Takes one completion per cycle from the functional units, in any order.
- Retires the oldest completed uop each cycle, in program order.
- Serves two operand lookups by ROB tag so the mapper can resolve source readiness.
- A retiring exception flushes the whole buffer.

Parameters:
- DEPTH, 32, number of ROB entries; must be a power of two.
- PTR_W, 5, log2(DEPTH); width of the tag and pointer fields.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- alloc_valid  input  1  mapper requests an entry this cycle
- alloc_dr  input  5  architectural destination register (0 = none)
- alloc_pc  input  32  uop PC
- alloc_eoi  input  1  last uop of the instruction
- alloc_exception  input  1  exception already detected at decode
- rob_write_ptr  output  32  tag for the next allocation, zero-extended from PTR_W
- rob_full  output  1  no free entry
- cmpl_valid  input  1  FU completion strobe
- cmpl_tag  input  PTR_W  ROB index being completed
- cmpl_result  input  32  result data
- cmpl_exception  input  1  FU-raised exception
- rd1_tag  input  PTR_W  operand lookup 1 tag
- rd1_ready  output  1  lookup 1 entry has a result
- rd1_data  output  32  lookup 1 result
- rd2_tag  input  PTR_W  operand lookup 2 tag
- rd2_ready  output  1  lookup 2 entry has a result
- rd2_data  output  32  lookup 2 result
- retire_valid  output  1  head uop retires this cycle
- retire_dr  output  5  retiring destination register
- retire_data  output  32  retiring result
- retire_pc  output  32  retiring PC
- retire_eoi  output  1  retiring eoi
- retire_exception  output  1  retiring uop carries an exception
- flush  output  1  pipeline flush, asserted with an exception retire

Behaviour:
- State:
  - head pointer, tail pointer, count (PTR_W+1 bits).
  - Per entry: valid, done, exc, dr, pc, eoi, data.
- Reset, synchronous, on any edge with rst=1, overriding all other inputs:
  - head=tail=count=0; all valid/done cleared.
  - Resulting outputs: rob_write_ptr=0, rob_full=0, retire_valid=0, flush=0, rd*_ready=0.
- rob_write_ptr = tail, zero-extended to 32 bits.
- rob_full = (count==DEPTH).
- Allocation:
  - Accepted when alloc_valid & !rob_full & !flush.
  - At the edge, entry[tail] gets valid=1, done=0, exc=alloc_exception and the payload; tail increments mod DEPTH.
  - An allocation request while rob_full=1 is dropped silently. The mapper must hold it.
  - A same-cycle retire does not relax rob_full.
- Decode exceptions: an entry allocated with alloc_exception=1 is also marked done=1 at allocation, so it can retire without an FU completion.
- Completion:
  - If cmpl_valid and entry[cmpl_tag].valid, the edge sets done=1, data=cmpl_result and exc |= cmpl_exception.
  - Completion to an invalid entry is ignored.
- Retire outputs are combinational from the head entry:
  - retire_valid = entry[head].valid & entry[head].done.
  - retire_* fields show the head payload; they are 0 when retire_valid=0.
  - There is no backpressure: the retire takes effect at the edge ending the cycle, head increments mod DEPTH, and entry[head].valid clears.
- Retire latency:
  - A completion sampled at edge N can retire in cycle N+1 at the earliest.
  - A same-cycle completion is not forwarded to retire.
- Throughput: at most one allocate, one complete and one retire per cycle.
  - count: +1 on allocate only, -1 on retire only, unchanged when both occur.
- Flush:
  - flush = retire_valid & entry[head].exc.
  - At that edge all valid/done bits clear and head=tail=count=0.
  - Any same-cycle allocation or completion is discarded.
- Operand lookup, combinational, per port:
  - ready = 1 if cmpl_valid & cmpl_tag==rd_tag & entry[rd_tag].valid; data = cmpl_result (bypass).
  - Otherwise ready = entry.valid & entry.done, data = entry.data.
  - data = 0 when ready=0.
- Wrap-around: pointers wrap DEPTH-1 -> 0. Full versus empty is distinguished only by count.

Test Plan:
- Reset then idle -> rob_write_ptr=0, rob_full=0, retire_valid=0, flush=0.
- Allocate 32 uops back-to-back (pc=0x100+4i) -> rob_write_ptr steps 0..31 then wraps to 0, rob_full=1 after the 32nd; a 33rd alloc_valid is dropped and count stays 32.
- Allocate tags 0,1,2; complete 2 then 0 (result 0xAA) -> tag 0 retires the cycle after its completion with retire_data=0xAA and retire_pc=0x100; tag 1 blocks; completing 1 then retires 1 and 2 on consecutive cycles.
- Complete tag 3 with 0x55 while rd1_tag=3 -> rd1_ready=1 and rd1_data=0x55 in the same cycle; the next cycle rd1 still reads 0x55 from storage.
- Full buffer with head done, alloc_valid=1 and retire in the same cycle -> retire occurs, allocation dropped, count becomes 31, rob_full drops the next cycle.
- Entry 5 at head completes with cmpl_exception=1 while tail=9, with a concurrent allocate -> flush=1 and retire_exception=1 for one cycle; next cycle head=tail=0, rob_write_ptr=0, the allocation is lost and no further retires occur.
- rst asserted mid-stream with 10 valid entries -> next cycle all outputs are at reset values; a stale completion to tag 4 is ignored.
